// File: rtl/ysyx_ifu_bridge.sv
// Bridges IFU fetch requests onto an AXI4 read master (AR + R channels).
// Define YSYX_IFU_BRIDGE_BURST_EN to fetch two-beat bursts in [0xa0000000, 0xc0000000].
module ysyx_ifu_bridge #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ifu_araddr_i,
  input  logic              ifu_arvalid_i,
  input  logic              ifu_required_i,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  output logic              ifu_rerr_o,
  output logic [DATA_W-1:0] io_master_araddr,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic              io_master_rvalid,
  output logic              io_master_rready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    R     = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] addr_q, addr_nxt;
  logic [7:0]        len_q, len_nxt;
  logic [7:0]        cnt_q, cnt_nxt;
  logic              ar_pend_q, ar_pend_nxt;

  logic [DATA_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              beat;
  logic              last_beat;

`ifdef YSYX_IFU_BRIDGE_BURST_EN
  localparam logic [DATA_W-1:0] BURST_LO   = DATA_W'(32'ha000_0000);
  localparam logic [DATA_W-1:0] BURST_HI   = DATA_W'(32'hc000_0000);
  localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-3){1'b1}}, 3'b000};

  // Burst window fetches the aligned 8-byte pair so the neighbouring word comes for free.
  always_comb begin
    if ((ifu_araddr_i >= BURST_LO) && (ifu_araddr_i <= BURST_HI)) begin
      req_addr = ifu_araddr_i & ALIGN_MASK;
      req_len  = 8'd1;
    end else begin
      req_addr = ifu_araddr_i;
      req_len  = 8'd0;
    end
  end
`else
  always_comb begin
    req_addr = ifu_araddr_i;
    req_len  = 8'd0;
  end
`endif

  // A DRAIN entered before the AR handshake keeps arvalid up and refuses R beats until it lands.
  assign io_master_arvalid = (state == AR) || ((state == DRAIN) && ar_pend_q);
  assign io_master_rready  = (state == R)  || ((state == DRAIN) && !ar_pend_q);
  assign io_master_araddr  = addr_q;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = 3'b010;
  assign io_master_arburst = 2'b01;

  assign beat      = io_master_rvalid && io_master_rready;
  assign last_beat = beat && ((cnt_q == 8'd0) || io_master_rlast);

  // Beats are forwarded combinationally; an abandoning IFU never sees the beat it walked away from.
  assign ifu_rvalid_o = (state == R) && beat && ifu_required_i;
  assign ifu_rerr_o   = ifu_rvalid_o && (io_master_rresp != 2'b00);
  assign ifu_rdata_o  = ifu_rvalid_o ? io_master_rdata : '0;

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    len_nxt     = len_q;
    cnt_nxt     = cnt_q;
    ar_pend_nxt = ar_pend_q;
    unique case (state)
      IDLE: begin
        ar_pend_nxt = 1'b0;
        if (ifu_arvalid_i) begin
          addr_nxt  = req_addr;
          len_nxt   = req_len;
          cnt_nxt   = req_len;
          state_nxt = AR;
        end
      end
      AR: begin
        if (io_master_arready) begin
          ar_pend_nxt = 1'b0;
          state_nxt   = ifu_required_i ? R : DRAIN;
        end else if (!ifu_required_i) begin
          ar_pend_nxt = 1'b1;
          state_nxt   = DRAIN;
        end
      end
      R: begin
        if (last_beat) begin
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          if (beat) cnt_nxt = cnt_q - 8'd1;
          if (!ifu_required_i) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ar_pend_q) begin
          if (io_master_arready) ar_pend_nxt = 1'b0;
        end else if (last_beat) begin
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (beat) begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      ar_pend_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      len_q     <= len_nxt;
      cnt_q     <= cnt_nxt;
      ar_pend_q <= ar_pend_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_bridge.sv
// Self-checking bench for ysyx_ifu_bridge: vector table, corner sequences, randomized fetches.
module tb_ysyx_ifu_bridge;

  localparam int DATA_W = 32;
`ifdef YSYX_IFU_BRIDGE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr_i;
  logic        ifu_arvalid_i;
  logic        ifu_required_i;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic        ifu_rerr_o;
  logic [31:0] io_master_araddr;
  logic        io_master_arvalid;
  logic        io_master_arready;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic [31:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;
  logic        io_master_rvalid;
  logic        io_master_rready;

  ysyx_ifu_bridge #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr_i(ifu_araddr_i), .ifu_arvalid_i(ifu_arvalid_i), .ifu_required_i(ifu_required_i),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_rerr_o(ifu_rerr_o),
    .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
    .io_master_arready(io_master_arready), .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rvalid(io_master_rvalid),
    .io_master_rready(io_master_rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which address/length the AXI side must see for a given fetch.
  function automatic int m_len(input logic [31:0] a);
    if (BURST && a >= 32'ha000_0000 && a <= 32'hc000_0000) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
    if (m_len(a) == 1) return {a[31:3], 3'b000};
    return a;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          ar_dly;
    int          r_dly;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  e0;
    logic [1:0]  e1;
    bit          drop;
    logic [31:0] x_addr;
    int          x_len;
  } vec_t;

  vec_t tbl[8];

  task automatic idle_inputs();
    ifu_arvalid_i     = 1'b0;
    ifu_araddr_i      = 32'h0;
    ifu_required_i    = 1'b1;
    io_master_arready = 1'b0;
    io_master_rvalid  = 1'b0;
    io_master_rdata   = 32'h0;
    io_master_rresp   = 2'b00;
    io_master_rlast   = 1'b0;
  endtask

  // One complete fetch with the bench acting as the AXI slave.
  task automatic fetch(input logic [31:0] a, input int ar_dly, input int r_dly,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] e0, input logic [1:0] e1, input bit drop,
                       input logic [31:0] x_addr, input int x_len, input string tag);
    logic [31:0] d;
    logic [1:0]  e;
    int nb;
    nb = x_len + 1;
    @(posedge clk); #1;
    ifu_araddr_i = a; ifu_arvalid_i = 1'b1; ifu_required_i = 1'b1;
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b0; ifu_araddr_i = $urandom;
    for (int i = 0; i < ar_dly; i++) begin
      io_master_rvalid = 1'b1; io_master_rdata = 32'hbad0_bad0; io_master_rlast = 1'b1;
      @(negedge clk);
      chk({tag, " arvalid_wait"}, 32'(io_master_arvalid), 32'd1);
      chk({tag, " stray_rready"}, 32'(io_master_rready), 32'd0);
      chk({tag, " stray_rvalid"}, 32'(ifu_rvalid_o), 32'd0);
      @(posedge clk); #1;
    end
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0; io_master_arready = 1'b1;
    @(negedge clk);
    chk({tag, " arvalid"}, 32'(io_master_arvalid), 32'd1);
    chk({tag, " araddr"}, io_master_araddr, x_addr);
    chk({tag, " arlen"}, 32'(io_master_arlen), 32'(x_len));
    chk({tag, " arsize"}, 32'(io_master_arsize), 32'd2);
    chk({tag, " arburst"}, 32'(io_master_arburst), 32'd1);
    @(posedge clk); #1;
    io_master_arready = 1'b0;
    if (drop) ifu_required_i = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < r_dly; i++) begin
        @(negedge clk);
        chk({tag, " rready_wait"}, 32'(io_master_rready), 32'd1);
        chk({tag, " no_pulse"}, 32'(ifu_rvalid_o), 32'd0);
        @(posedge clk); #1;
      end
      d = (b == 0) ? d0 : d1;
      e = (b == 0) ? e0 : e1;
      io_master_rvalid = 1'b1; io_master_rdata = d; io_master_rresp = e;
      io_master_rlast = (b == nb - 1);
      @(negedge clk);
      chk({tag, " rready"}, 32'(io_master_rready), 32'd1);
      chk({tag, " rvalid_o"}, 32'(ifu_rvalid_o), drop ? 32'd0 : 32'd1);
      chk({tag, " rdata_o"}, ifu_rdata_o, drop ? 32'd0 : d);
      chk({tag, " rerr_o"}, 32'(ifu_rerr_o), (drop || e == 2'b00) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      io_master_rvalid = 1'b0; io_master_rlast = 1'b0; io_master_rresp = 2'b00;
    end
    ifu_required_i = 1'b1;
    @(negedge clk);
    chk({tag, " idle_rready"}, 32'(io_master_rready), 32'd0);
    chk({tag, " idle_arvalid"}, 32'(io_master_arvalid), 32'd0);
    chk({tag, " idle_rvalid_o"}, 32'(ifu_rvalid_o), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("reset arvalid", 32'(io_master_arvalid), 32'd0);
    chk("reset rready", 32'(io_master_rready), 32'd0);
    chk("reset rvalid_o", 32'(ifu_rvalid_o), 32'd0);
    chk("reset rerr_o", 32'(ifu_rerr_o), 32'd0);
    chk("reset arlen", 32'(io_master_arlen), 32'd0);
    chk("reset araddr", io_master_araddr, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    tbl[0] = '{32'h3000_0000, 2, 3, 32'h0000_0413, 32'h0, 2'b00, 2'b00, 1'b0, 32'h3000_0000, 0};
    tbl[1] = '{32'ha000_0004, 0, 1, 32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00, 1'b0,
               BURST ? 32'ha000_0000 : 32'ha000_0004, BURST ? 1 : 0};
    tbl[2] = '{32'h3000_0008, 1, 0, 32'hdead_beef, 32'h0, 2'b00, 2'b00, 1'b1, 32'h3000_0008, 0};
    tbl[3] = '{32'h3000_0010, 0, 0, 32'hcafe_f00d, 32'h0, 2'b10, 2'b00, 1'b0, 32'h3000_0010, 0};
    tbl[4] = '{32'hc000_0000, 1, 2, 32'h1234_5678, 32'h9abc_def0, 2'b00, 2'b11, 1'b0,
               32'hc000_0000, BURST ? 1 : 0};
    tbl[5] = '{32'h9fff_fffc, 0, 0, 32'h0bad_c0de, 32'h0, 2'b00, 2'b00, 1'b0, 32'h9fff_fffc, 0};
    tbl[6] = '{32'hc000_0004, 0, 1, 32'h5555_aaaa, 32'h0, 2'b01, 2'b00, 1'b0, 32'hc000_0004, 0};
    tbl[7] = '{32'ha000_000c, 1, 1, 32'h7777_0000, 32'h8888_0000, 2'b00, 2'b00, 1'b1,
               BURST ? 32'ha000_0008 : 32'ha000_000c, BURST ? 1 : 0};
    for (int v = 0; v < 8; v++)
      fetch(tbl[v].addr, tbl[v].ar_dly, tbl[v].r_dly, tbl[v].d0, tbl[v].d1, tbl[v].e0,
            tbl[v].e1, tbl[v].drop, tbl[v].x_addr, tbl[v].x_len, $sformatf("vec%0d", v));

    // A request coinciding with the final beat is ignored.
    @(posedge clk); #1;
    ifu_araddr_i = 32'h3000_0020; ifu_arvalid_i = 1'b1;
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b0; io_master_arready = 1'b1;
    @(posedge clk); #1;
    io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rdata = 32'h0000_0013; io_master_rlast = 1'b1;
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h4000_0000;
    @(negedge clk);
    chk("final_beat pulse", 32'(ifu_rvalid_o), 32'd1);
    @(posedge clk); #1;
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0; ifu_arvalid_i = 1'b0;
    @(negedge clk);
    chk("final_beat req_ignored", 32'(io_master_arvalid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("final_beat still_idle", 32'(io_master_arvalid), 32'd0);

    // Stray R beat while idle.
    io_master_rvalid = 1'b1; io_master_rdata = 32'hffff_ffff; io_master_rlast = 1'b1;
    @(negedge clk);
    chk("idle stray rready", 32'(io_master_rready), 32'd0);
    chk("idle stray rdata_o", ifu_rdata_o, 32'd0);
    @(posedge clk); #1;
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0;

    // Abandon before the AR handshake: address phase still completes, beat is drained.
    @(posedge clk); #1;
    ifu_araddr_i = 32'h3000_0024; ifu_arvalid_i = 1'b1;
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b0; ifu_required_i = 1'b0;
    @(negedge clk);
    chk("ar_drop arvalid", 32'(io_master_arvalid), 32'd1);
    @(posedge clk); #1;
    io_master_rvalid = 1'b1; io_master_rdata = 32'h1357_9bdf; io_master_rlast = 1'b1;
    @(negedge clk);
    chk("ar_drop arvalid_held", 32'(io_master_arvalid), 32'd1);
    chk("ar_drop rready_blocked", 32'(io_master_rready), 32'd0);
    @(posedge clk); #1;
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0; io_master_arready = 1'b1;
    @(negedge clk);
    chk("ar_drop araddr", io_master_araddr, 32'h3000_0024);
    @(posedge clk); #1;
    io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rdata = 32'hdead_beef; io_master_rlast = 1'b1;
    @(negedge clk);
    chk("ar_drop rready", 32'(io_master_rready), 32'd1);
    chk("ar_drop no_pulse", 32'(ifu_rvalid_o), 32'd0);
    chk("ar_drop rdata_o", ifu_rdata_o, 32'd0);
    @(posedge clk); #1;
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0; ifu_required_i = 1'b1;
    @(negedge clk);
    chk("ar_drop idle", 32'(io_master_rready), 32'd0);

    // Reset while a beat is on the bus and a new request is pending.
    @(posedge clk); #1;
    ifu_araddr_i = 32'h3000_0030; ifu_arvalid_i = 1'b1;
    @(posedge clk); #1;
    ifu_arvalid_i = 1'b0; io_master_arready = 1'b1;
    @(posedge clk); #1;
    io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rdata = 32'h0000_0055; io_master_rresp = 2'b10;
    io_master_rlast = 1'b1; ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h3000_0040;
    #1;
    chk("pre_rst pulse", 32'(ifu_rvalid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst rvalid_o", 32'(ifu_rvalid_o), 32'd0);
    chk("rst rerr_o", 32'(ifu_rerr_o), 32'd0);
    chk("rst rdata_o", ifu_rdata_o, 32'd0);
    chk("rst rready", 32'(io_master_rready), 32'd0);
    chk("rst arvalid", 32'(io_master_arvalid), 32'd0);
    chk("rst arlen", 32'(io_master_arlen), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(32'h3000_0000, 2, 3, 32'h0000_0413, 32'h0, 2'b00, 2'b00, 1'b0,
          32'h3000_0000, 0, "post_rst");

    // Randomized fetches against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int pick;
      pick = $urandom_range(0, 3);
      case (pick)
        0:       a = $urandom;
        1:       a = 32'ha000_0000 + ($urandom & 32'h1fff_fffc);
        2: begin
          case ($urandom_range(0, 3))
            0:       a = 32'ha000_0000;
            1:       a = 32'hc000_0000;
            2:       a = 32'h9fff_fffc;
            default: a = 32'hc000_0004;
          endcase
        end
        default: a = 32'h3000_0000 + ($urandom & 32'h0000_fffc);
      endcase
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, $urandom,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
            m_addr(a), m_len(a), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu_bridge.md
YSYX_IFU_BRIDGE -- requirements
Module: ysyx_ifu_bridge

Interface
REQ-001 SHALL have parameter: DATA_W, 32, address and data width.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: ifu_araddr_i  in  DATA_W  fetch address from the IFU.
REQ-005 SHALL have port: ifu_arvalid_i  in  1  fetch request valid.
REQ-006 SHALL have port: ifu_required_i  in  1  IFU still owns the transaction; low means abandoned.
REQ-007 SHALL have port: ifu_rdata_o  out  DATA_W  returned instruction word.
REQ-008 SHALL have port: ifu_rvalid_o  out  1  one-cycle pulse per returned beat.
REQ-009 SHALL have port: ifu_rerr_o  out  1  one-cycle pulse with a beat carrying non-OKAY response.
REQ-010 SHALL have ports: io_master_araddr out DATA_W; io_master_arvalid out 1; io_master_arready in 1; io_master_arlen out 8; io_master_arsize out 3; io_master_arburst out 2.
REQ-011 SHALL have ports: io_master_rdata in DATA_W; io_master_rresp in 2; io_master_rlast in 1; io_master_rvalid in 1; io_master_rready out 1.

Function
REQ-012 SHALL implement states IDLE, AR, R, DRAIN.
REQ-013 IDLE: on ifu_arvalid_i=1, SHALL latch address, compute beat count, go to AR; arvalid asserted next cycle.
REQ-014 AR: io_master_arvalid=1, araddr/arlen/arsize/arburst held stable until arready=1; on handshake go to R.
REQ-015 io_master_arsize SHALL be 3'b010; io_master_arburst SHALL be 2'b01 (INCR).
REQ-016 R: io_master_rready=1; each rvalid beat SHALL produce ifu_rvalid_o=1 and ifu_rdata_o=rdata in the same cycle (zero added latency, combinational pass-through).
REQ-017 ifu_rerr_o SHALL equal rvalid & rready & (rresp != 2'b00) while in R.
REQ-018 Beat counter SHALL decrement per beat; on the final beat (counter==0 or rlast=1, whichever first) SHALL return to IDLE.
REQ-019 ifu_arvalid_i in the same cycle as the final beat SHALL be ignored; a new request is accepted only from IDLE (one-cycle gap minimum).
REQ-020 If ifu_required_i=0 during AR or R, SHALL move to DRAIN (AR handshake still completed; AXI never aborted).
REQ-021 DRAIN: rready=1, ifu_rvalid_o and ifu_rerr_o forced 0; on final beat return to IDLE.
REQ-022 ifu_rdata_o SHALL be 0 whenever ifu_rvalid_o=0.
REQ-023 Unexpected rvalid in IDLE or AR SHALL be ignored (rready=0 there).

Reset
REQ-024 rst SHALL force state IDLE, beat counter 0, latched address 0.
REQ-025 During reset: io_master_arvalid=0, io_master_rready=0, ifu_rvalid_o=0, ifu_rerr_o=0, arlen=0.
REQ-026 Reset mid-transaction SHALL drop the transaction; no beat forwarded after rst rises.

Configuration
REQ-027 Macro YSYX_IFU_BRIDGE_BURST_EN SHALL select burst support.
REQ-028 Defined: addresses in [0xa0000000, 0xc0000000] SHALL issue arlen=1, araddr=ifu_araddr_i & ~32'h7, two beats returned in address order; other addresses single-beat.
REQ-029 Undefined: every request SHALL issue arlen=0, araddr=ifu_araddr_i unmodified, one beat.

Verification
REQ-030 Single fetch 0x30000000, arready after 2 cycles, rdata 0x00000413 after 3 more -> one ifu_rvalid_o pulse with 0x00000413, state IDLE next cycle.
REQ-031 Burst enabled, fetch 0xa0000004 -> araddr 0xa0000000, arlen 1; beats 0x11111111, 0x22222222 -> two pulses in that order.
REQ-032 Burst disabled, fetch 0xa0000004 -> araddr 0xa0000004, arlen 0, one pulse.
REQ-033 ifu_required_i dropped after AR handshake, rdata 0xdeadbeef returned -> rready=1, no ifu_rvalid_o pulse, back to IDLE.
REQ-034 rresp=2'b10 on beat -> ifu_rvalid_o and ifu_rerr_o both pulse in the same cycle.
REQ-035 rst asserted while in R with arvalid pending new request -> all outputs 0 immediately; first fetch after release completes normally.
